alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit combinational ALU (Sel opcodes 0x0-0xB).
- Accepts operation requests over valid/ready handshakes and drives the ALU operand/opcode inputs from registers.
- Captures the ALU result and flags one cycle later and returns them on a single tagged response channel with backpressure.
- Screens illegal opcodes and divide-by-zero before they reach the ALU, and keeps a saturating error count.

## Interface
Parameters: none (widths fixed to the ALU: 8-bit operands, 4-bit opcode, 4-bit flags).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_a, req0_b  in  8  requester 0 operands
- req0_sel  in  4  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as requester 0, for requester 1
- alu_a, alu_b  out  8  registered operands to the ALU
- alu_sel  out  4  registered opcode to the ALU
- alu_out  in  8  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_flag  in  4  ALU flags: [0] zero, [1] carry/shift overflow, [2] multiply overflow, [3] borrow/A<B
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response when valid&ready
- rsp_id  out  1  requester index the response belongs to
- rsp_out  out  8  result
- rsp_flag  out  4  flags
- rsp_err  out  1  operation rejected (illegal opcode or divide-by-zero)
- err_count  out  8  count of rejected operations, saturates at 255

## Operation
- FSM states: IDLE, EXEC, RESP. Exactly one operation in flight; no pipelining.
- IDLE:
  - Arbitration is combinational. If only one reqN_valid is high, that requester is granted. If both are high, grant goes to the requester not served last. last_served resets to 1, so requester 0 wins the first tie.
  - reqN_ready is high only for the granted requester, and only in IDLE. Both are low in EXEC/RESP.
  - On accept: load alu_a/alu_b/alu_sel from the granted request, record the id, update last_served, set err_pend = (sel > 4'hB) or (sel == 4'h3 and b == 0). Go to EXEC.
- EXEC (one cycle):
  - Normal operation: capture rsp_out <= alu_out, rsp_flag <= alu_flag, rsp_err <= 0.
  - err_pend set: rsp_out <= 8'h00, rsp_flag <= 4'h0, rsp_err <= 1, and err_count increments unless it is already 255.
  - Set rsp_valid. Go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid is high and rsp_ready is low.
  - When rsp_ready is high: clear rsp_valid and go to IDLE. New requests are accepted no earlier than the following cycle.
- alu_a/alu_b/alu_sel keep their last loaded values outside EXEC. Illegal opcodes are still driven to the ALU; the ALU output is ignored in that case.
- Requester inputs are sampled only at the accept edge. Changes while not ready are ignored. A requester may drop valid without being served.

## Timing
- Reset (async, rst_n low): state=IDLE, last_served=1, err_pend=0. alu_a=alu_b=0, alu_sel=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_flag=0, rsp_err=0, err_count=0.
  - reqN_ready follows the IDLE arbitration once rst_n deasserts.
  - Reset in EXEC or RESP discards the operation without producing a response.
- Latency:
  - accept at edge N; alu_* valid after edge N; result captured at edge N+1; rsp_valid high after edge N+1.
  - With rsp_ready held high: rsp_valid is high for exactly one cycle, IDLE is reached after edge N+2, and the next accept can happen at edge N+3.
  - Throughput: one operation per 3 cycles.
- The ALU path is combinational within the EXEC cycle, from alu_* registers through the ALU to the rsp_* registers.
- err_count saturates: an error at 255 leaves it at 255.

## Test plan
- Single op: req0 A=200, B=100, sel=0 -> req0_ready high in the accept cycle; two edges later rsp_valid=1, rsp_id=0, rsp_out=8'd44, rsp_flag=4'b0010, rsp_err=0.
- Contention: both valid continuously after reset, req0 sel=1 A=5 B=9, req1 sel=6 A=8'hF0 B=8'h0F -> grants alternate 0,1,0,1. Responses: id0 out=8'hFC flag=4'b1000; id1 out=0 flag=4'b0001.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_* stable; req0_ready and req1_ready stay low; completes on the first cycle rsp_ready is high.
- Rejections: sel=3, B=0 and then sel=4'hC -> each gives rsp_err=1, rsp_out=0, rsp_flag=0; err_count goes 1 then 2. Issue 300 rejected ops -> err_count=255.
- Reset mid-operation: assert rst_n low during EXEC, then during RESP -> all outputs at reset values immediately; no response emerges. After release, the tie goes to requester 0.
- Divide and shift: sel=3 A=7 B=9 -> out=0, flag=4'b1001. sel=4 A=8'h81 B=1 -> out=8'h02, flag[1]=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for the shared 8-bit ALU.
// Runs one operation at a time and returns the result on a tagged response channel.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_out,
  output logic [3:0] rsp_flag,
  output logic       rsp_err,
  output logic [7:0] err_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(4'hB);
  localparam logic [SEL_W-1:0] SEL_DIV = SEL_W'(4'h3);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_grant;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [SEL_W-1:0]    w_sel;
  logic                w_err;

  logic                r_last;
  logic                r_id;
  logic                r_err_pend;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [SEL_W-1:0]    r_alu_sel;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_out;
  logic [FLAG_W-1:0]   r_rsp_flag;
  logic                r_rsp_err;
  logic [CNT_W-1:0]    r_err_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, arbitration and ready; on a tie the requester not served last wins
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_grant     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept    = 1'b1;
          req0_ready  = ~w_grant;
          req1_ready  = w_grant;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_a   = w_grant ? req1_a   : req0_a;
  assign w_b   = w_grant ? req1_b   : req0_b;
  assign w_sel = w_grant ? req1_sel : req0_sel;
  assign w_err = (w_sel > SEL_MAX) || ((w_sel == SEL_DIV) && (w_b == '0));

  // Operand load on accept, result capture in EXEC, response hold until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_err_pend  <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_flag  <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a    <= w_a;
        r_alu_b    <= w_b;
        r_alu_sel  <= w_sel;
        r_id       <= w_grant;
        r_last     <= w_grant;
        r_err_pend <= w_err;
      end
      if (r_state == S_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        if (r_err_pend) begin
          r_rsp_out  <= '0;
          r_rsp_flag <= '0;
          r_rsp_err  <= 1'b1;
          if (r_err_count != CNT_MAX) r_err_count <= CNT_W'(r_err_count + 1'b1);
        end else begin
          r_rsp_out  <= alu_out;
          r_rsp_flag <= alu_flag;
          r_rsp_err  <= 1'b0;
        end
      end
      if ((r_state == S_RESP) && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_out   = r_rsp_out;
  assign rsp_flag  = r_rsp_flag;
  assign rsp_err   = r_rsp_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, transaction model and scoreboard
// with a monitor that checks every presented response against the expected queue.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel, alu_flag;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0] rsp_out, err_count;
  logic [3:0] rsp_flag;

  typedef struct {
    bit         id;
    logic [7:0] out;
    logic [3:0] flag;
    bit         err;
    logic [7:0] ecnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   m_idle, m_exec, m_resp, m_last;
  int   m_errs;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err), .err_count(err_count)
  );

  // Behavioural ALU: returns {flag, out}; flags = {a<b, mul ovf, carry/shift ovf, zero}
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [7:0]  o;
    logic        c, m;
    logic [15:0] w;
    c = 1'b0; m = 1'b0; o = 8'h00;
    case (s)
      4'h0: begin w = 16'(a) + 16'(b); o = w[7:0]; c = w[8]; end
      4'h1: o = a - b;
      4'h2: begin w = 16'(a) * 16'(b); o = w[7:0]; m = |w[15:8]; end
      4'h3: o = (b == 8'h00) ? 8'hFF : a / b;
      4'h4: begin w = 16'(a) << b[3:0]; o = w[7:0]; c = |w[15:8]; end
      4'h5: o = a >> b[3:0];
      4'h6: o = a & b;
      4'h7: o = a | b;
      4'h8: o = a ^ b;
      4'h9: o = ~(a | b);
      4'hA: o = ~(a & b);
      4'hB: o = ~(a ^ b);
      default: return 12'hFA5;
    endcase
    return {a < b, m, c, o == 8'h00, o};
  endfunction

  always_comb {alu_flag, alu_out} = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    exp_t e;
    logic [11:0] r;
    e.id = id;
    if (s > 4'hB || (s == 4'h3 && b == 8'h00)) begin
      if (m_errs < 255) m_errs++;
      e.out = 8'h00; e.flag = 4'h0; e.err = 1'b1;
    end else begin
      r = alu_f(a, b, s);
      e.out = r[7:0]; e.flag = r[11:8]; e.err = 1'b0;
    end
    e.ecnt = 8'(m_errs);
    return e;
  endfunction

  // One clock of stimulus; checks handshake outputs against the model, then advances it
  task automatic step(input bit v0, input bit v1,
                      input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] s0,
                      input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] s1,
                      input bit rr);
    bit g, any;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    rsp_ready  = rr;
    #1;
    any = v0 || v1;
    g   = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", req0_ready, m_idle && any && !g);
    chk("req1_ready", req1_ready, m_idle && any && g);
    chk("rsp_valid", rsp_valid, m_resp);
    if (m_idle && any) begin
      exp_q.push_back(g ? make_exp(1'b1, a1, b1, s1) : make_exp(1'b0, a0, b0, s0));
      m_last = g; m_idle = 0; m_exec = 1;
    end else if (m_exec) begin
      m_exec = 0; m_resp = 1;
    end else if (m_resp && rr) begin
      m_resp = 0; m_idle = 1;
    end
  endtask

  task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input bit rr);
    step(1, 0, a, b, s, 8'h00, 8'h00, 4'h0, rr);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, rr);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop at once
  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_flag", rsp_flag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    exp_q.delete();
    m_idle = 1; m_exec = 0; m_resp = 0; m_last = 1; m_errs = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every presented response with the queue head, pop on handshake
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          chk("rsp_id", rsp_id, exp_q[0].id);
          chk("rsp_out", rsp_out, exp_q[0].out);
          chk("rsp_flag", rsp_flag, exp_q[0].flag);
          chk("rsp_err", rsp_err, exp_q[0].err);
          chk("err_count", err_count, exp_q[0].ecnt);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit exp_alt;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    #2 do_reset();

    // Single add with carry
    op0(8'd200, 8'd100, 4'h0, 1);
    chk("t1_accept", req0_ready, 1);
    idle(2, 1);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_out", rsp_out, 8'd44);
    chk("t1_flag", rsp_flag, 4'b0010);
    chk("t1_err", rsp_err, 0);
    idle(2, 1);

    // Contention: grants alternate starting with requester 0
    do_reset();
    exp_alt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 8'd5, 8'd9, 4'h1, 8'hF0, 8'h0F, 4'h6, 1);
      if (req0_ready || req1_ready) begin
        chk("alt_grant", req1_ready, exp_alt);
        exp_alt = ~exp_alt;
      end
      if (rsp_valid) chk("alt_out", {rsp_flag, rsp_out}, rsp_id ? 12'h100 : 12'h8FC);
    end
    idle(3, 1);

    // Backpressure with both requesters waiting
    op0(8'd10, 8'd20, 4'h2, 0);
    step(1, 1, 8'd3, 8'd4, 4'h7, 8'd6, 8'd7, 4'h8, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'd3, 8'd4, 4'h7, 8'd6, 8'd7, 4'h8, 0);
      chk("bp_hold", rsp_valid, 1);
    end
    step(1, 1, 8'd3, 8'd4, 4'h7, 8'd6, 8'd7, 4'h8, 1);
    idle(4, 1);

    // Divide and shift
    op0(8'd7, 8'd9, 4'h3, 1);
    idle(2, 1);
    chk("div_out", {rsp_flag, rsp_out}, 12'h900);
    idle(1, 1);
    op0(8'h81, 8'd1, 4'h4, 1);
    idle(2, 1);
    chk("shl_out", rsp_out, 8'h02);
    chk("shl_flag1", rsp_flag[1], 1);
    idle(1, 1);

    // Rejections and saturation
    do_reset();
    op0(8'd7, 8'd0, 4'h3, 1);
    idle(2, 1);
    chk("rej1_cnt", err_count, 1);
    chk("rej1_err", {rsp_err, rsp_flag, rsp_out}, 13'h1000);
    idle(1, 1);
    op0(8'd1, 8'd2, 4'hC, 1);
    idle(2, 1);
    chk("rej2_cnt", err_count, 2);
    chk("rej2_err", {rsp_err, rsp_flag, rsp_out}, 13'h1000);
    idle(1, 1);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) op0(8'($urandom), 8'd0, 4'h3, 1);
      else            op0(8'($urandom), 8'($urandom), 4'($urandom_range(12, 15)), 1);
      idle(2, 1);
    end
    chk("sat_cnt", err_count, 255);

    // Reset during EXEC, then during RESP
    do_reset();
    op0(8'd1, 8'd1, 4'h0, 0);
    idle(1, 0);
    do_reset();
    idle(3, 1);
    op0(8'd2, 8'd3, 4'h0, 0);
    idle(2, 0);
    chk("pre_rst_valid", rsp_valid, 1);
    do_reset();
    idle(2, 1);
    step(1, 1, 8'd1, 8'd2, 4'h7, 8'd3, 8'd4, 4'h8, 1);
    chk("post_rst_tie", req0_ready, 1);
    idle(3, 1);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 4'($urandom),
           8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 4'($urandom),
           $urandom_range(0, 2) != 0);
    end
    idle(6, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
